// File: rtl/quad_decoder.sv
// quad_decoder: quadrature A/B decoder producing step strobes, direction, signed position and error count.
// Optional glitch filter after the synchronizer is enabled by defining QUAD_FILTER_EN.
module quad_decoder #(
    parameter int FILT_N = 8,
    parameter int FILT_W = 4,
    parameter int POS_W  = 16,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_i,
    input  logic             b_i,
    input  logic             clr_i,
    output logic             en_o,
    output logic             up_o,
    output logic             err_o,
    output logic [POS_W-1:0] pos_o,
    output logic [ERR_W-1:0] err_cnt_o
);
    if (FILT_N < 2 || (2 ** FILT_W) <= FILT_N) begin : g_bad_cfg
        $error("quad_decoder: FILT_N must be >= 2 and below 2**FILT_W");
    end
`ifdef QUAD_FILTER_EN
    localparam int VLD_W = 3;
`else
    localparam int VLD_W = 2;
`endif
    logic [1:0]       sync1_q, sync2_q, state_q, state_d, acc;
    logic [VLD_W-1:0] vld_q;
    logic             init_q, init_d, en_q, en_d, up_q, up_d, err_q, err_d;
    logic             fwd, rev, ill, live;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [ERR_W-1:0] ecnt_q, ecnt_d;

    // vld_q marks when the pipeline holds real pin samples rather than reset zeros
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            vld_q   <= '0;
        end else begin
            sync1_q <= {a_i, b_i};
            sync2_q <= sync1_q;
            vld_q   <= {vld_q[VLD_W-2:0], 1'b1};
        end
    end

`ifdef QUAD_FILTER_EN
    logic [1:0]        acc_q, acc_d, last_q;
    logic [FILT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (!vld_q[2])
            acc_d = sync2_q;
        else if (sync2_q != last_q || sync2_q == acc_q)
            cnt_d = '0;
        else if (cnt_q == FILT_W'(FILT_N - 1)) begin
            acc_d = sync2_q;
            cnt_d = '0;
        end else
            cnt_d = cnt_q + FILT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            last_q <= '0;
            cnt_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            last_q <= sync2_q;
            cnt_q  <= cnt_d;
        end
    end

    assign acc = acc_q;
`else
    assign acc = sync2_q;
`endif

    assign live = vld_q[VLD_W-1];

    // Gray successor of {A,B} is {B,~A}; predecessor is {~B,A}
    always_comb begin
        fwd     = acc == {state_q[0], ~state_q[1]};
        rev     = acc == {~state_q[0], state_q[1]};
        ill     = acc == ~state_q;
        init_d  = init_q & ~live;
        state_d = live ? acc : state_q;
        en_d    = ~init_q & (fwd | rev);
        err_d   = ~init_q & ill;
        up_d    = en_d ? fwd : up_q;
        pos_d   = clr_i ? '0 : en_d ? (fwd ? pos_q + POS_W'(1) : pos_q - POS_W'(1)) : pos_q;
        ecnt_d  = clr_i ? '0 : (err_d && !(&ecnt_q)) ? ecnt_q + ERR_W'(1) : ecnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
            init_q  <= 1'b1;
            en_q    <= 1'b0;
            up_q    <= 1'b1;
            err_q   <= 1'b0;
            pos_q   <= '0;
            ecnt_q  <= '0;
        end else begin
            state_q <= state_d;
            init_q  <= init_d;
            en_q    <= en_d;
            up_q    <= up_d;
            err_q   <= err_d;
            pos_q   <= pos_d;
            ecnt_q  <= ecnt_d;
        end
    end

    assign en_o      = en_q;
    assign up_o      = up_q;
    assign err_o     = err_q;
    assign pos_o     = pos_q;
    assign err_cnt_o = ecnt_q;
endmodule
